// File: rtl/gray_seq_gen.sv
// Gray-code sequence source: a binary counter presented as registered Gray and binary
// codes behind a valid/ready handshake, with wrap and illegal-load flags.
module gray_seq_gen #(
    parameter int unsigned WIDTH        = 4,
    parameter bit          STOP_ON_WRAP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap,
    output logic             load_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic             busy_q, busy_d;

    logic             xfer;
    logic             at_wrap;
    logic [WIDTH-1:0] cnt_step;

    assign xfer     = valid_q & out_ready;
    assign at_wrap  = up_dn ? (cnt_q == '1) : (cnt_q == '0);
    assign cnt_step = up_dn ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop with a concurrent transfer finishes the beat and goes idle directly
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = xfer ? S_IDLE : S_DRAIN;
                end else if (xfer && at_wrap && STOP_ON_WRAP) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (xfer) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter and output next values; the code registers follow cnt_d so Gray and binary always match
    always_comb begin
        cnt_d = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    cnt_d = load_val;
                end
            end
            S_RUN, S_DRAIN: begin
                if (xfer) begin
                    cnt_d = cnt_step;
                end
            end
            default: cnt_d = cnt_q;
        endcase
        gray_d     = cnt_d ^ (cnt_d >> 1);
        valid_d    = (state_d != S_IDLE);
        busy_d     = (state_d != S_IDLE);
        wrap_d     = xfer & at_wrap;
        load_err_d = load & (state_q != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            gray_q     <= '0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            gray_q     <= gray_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
            busy_q     <= busy_d;
        end
    end

    assign out_valid = valid_q;
    assign gray_out  = gray_q;
    assign bin_out   = cnt_q;
    assign wrap      = wrap_q;
    assign load_err  = load_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gray_seq_gen.sv
// Bench for gray_seq_gen: two instances (STOP_ON_WRAP 0 and 1) driven in lockstep and
// compared each cycle against an arithmetic model, plus directed constant checks.
module tb_gray_seq_gen;

    localparam int unsigned W = 4;
    localparam int unsigned M = 1 << W;
    localparam int unsigned VW = 2 * W + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, stop, up_dn, load, out_ready;
    logic [W-1:0] load_val;

    logic         v0, w0, le0, bz0;
    logic [W-1:0] g0, b0;
    logic         v1, w1, le1, bz1;
    logic [W-1:0] g1, b1;

    gray_seq_gen #(.WIDTH(W), .STOP_ON_WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .up_dn(up_dn),
        .load(load), .load_val(load_val), .out_ready(out_ready),
        .out_valid(v0), .gray_out(g0), .bin_out(b0), .wrap(w0),
        .load_err(le0), .busy(bz0)
    );

    gray_seq_gen #(.WIDTH(W), .STOP_ON_WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .up_dn(up_dn),
        .load(load), .load_val(load_val), .out_ready(out_ready),
        .out_valid(v1), .gray_out(g1), .bin_out(b1), .wrap(w1),
        .load_err(le1), .busy(bz1)
    );

    // Model: phase 0 = idle, 1 = issuing, 2 = draining; count kept as a plain integer
    int m_phase [2];
    int m_cnt   [2];
    bit m_wrap  [2];
    bit m_lerr  [2];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [VW-1:0] exp_vec(int k);
        bit valid;
        int g;
        valid = (m_phase[k] != 0);
        g     = m_cnt[k] ^ (m_cnt[k] / 2);
        return {valid, W'(g), W'(m_cnt[k]), m_wrap[k], m_lerr[k], valid};
    endfunction

    function automatic logic [VW-1:0] obs_vec(int k);
        if (k == 0) return {v0, g0, b0, w0, le0, bz0};
        return {v1, g1, b1, w1, le1, bz1};
    endfunction

    task automatic model_step(int k, bit stop_on_wrap);
        bit valid, taken, crosses;
        int nxt;
        valid   = (m_phase[k] != 0);
        taken   = valid && out_ready;
        nxt     = up_dn ? (m_cnt[k] + 1) % M : (m_cnt[k] + M - 1) % M;
        crosses = taken && (up_dn ? (m_cnt[k] == M - 1) : (m_cnt[k] == 0));
        if (rst) begin
            m_phase[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0; m_lerr[k] = 0;
            return;
        end
        m_wrap[k] = crosses;
        m_lerr[k] = load && (m_phase[k] != 0);
        if (m_phase[k] == 0) begin
            if (load) m_cnt[k] = int'(load_val);
            if (start) m_phase[k] = 1;
        end else begin
            if (taken) m_cnt[k] = nxt;
            if (m_phase[k] == 2) begin
                if (taken) m_phase[k] = 0;
            end else if (stop) begin
                m_phase[k] = taken ? 0 : 2;
            end else if (crosses && stop_on_wrap) begin
                m_phase[k] = 0;
            end
        end
    endtask

    task automatic drive(bit r, bit s, bit sp, bit u, bit l, logic [W-1:0] lv, bit rdy);
        rst = r; start = s; stop = sp; up_dn = u; load = l; load_val = lv; out_ready = rdy;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 1, 1, 4'd9, 1);
        cycle();
        cycle();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_load_start();
        drive(1, 0, 0, 1, 0, 4'd0, 1);
        cycle();
        drive(0, 1, 0, 1, 1, 4'd5, 1);
        cycle();
        n_checks++;
        if ({v0, g0, b0} !== {1'b1, 4'b0111, 4'd5}) begin
            n_fail++;
            $display("FAIL load_start_first dut0: got %b/%b/%0d expected 1/0111/5", v0, g0, b0);
        end
        drive(0, 0, 0, 1, 0, 4'd0, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL load_start_seq dut%0d step%0d: got %h expected %h", k, i, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_wrap();
        drive(1, 0, 0, 1, 0, 4'd0, 1);
        cycle();
        drive(0, 1, 0, 1, 1, 4'd15, 1);
        cycle();
        n_checks++;
        if ({b0, g0} !== {4'd15, 4'b1000}) begin
            n_fail++;
            $display("FAIL wrap_pre dut0: got bin %0d gray %b expected 15 1000", b0, g0);
        end
        drive(0, 0, 0, 1, 0, 4'd0, 1);
        cycle();
        n_checks++;
        if ({b0, g0, w0, v0, v1, w1} !== {4'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_cross: got bin %0d gray %b wrap %b v0 %b v1 %b w1 %b expected 0 0000 1 1 0 1",
                     b0, g0, w0, v0, v1, w1);
        end
        for (int i = 0; i < 2; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL wrap_after dut%0d step%0d: got %h expected %h", k, i, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held_g, held_b;
        drive(1, 0, 0, 1, 0, 4'd0, 0);
        cycle();
        drive(0, 1, 0, 1, 1, 4'd3, 0);
        cycle();
        held_g = g0;
        held_b = b0;
        drive(0, 0, 0, 1, 0, 4'd0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if ({v0, g0, b0} !== {1'b1, held_g, held_b} || obs_vec(0) !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL backpressure_hold step%0d: got %h expected %h", i, obs_vec(0), exp_vec(0));
            end
        end
        drive(0, 0, 0, 1, 0, 4'd0, 1);
        cycle();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL backpressure_release dut%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_stop_drain();
        drive(1, 0, 0, 1, 0, 4'd0, 0);
        cycle();
        drive(0, 1, 0, 1, 1, 4'd10, 0);
        cycle();
        drive(0, 0, 1, 1, 0, 4'd0, 0);
        cycle();
        drive(0, 0, 0, 1, 0, 4'd0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL drain_hold dut%0d step%0d: got %h expected %h", k, i, obs_vec(k), exp_vec(k));
                end
            end
        end
        drive(0, 0, 0, 1, 0, 4'd0, 1);
        cycle();
        n_checks++;
        if ({v0, bz0, b0} !== {1'b0, 1'b0, 4'd11}) begin
            n_fail++;
            $display("FAIL drain_exit dut0: got valid %b busy %b bin %0d expected 0 0 11", v0, bz0, b0);
        end
        cycle();
        n_checks++;
        if (obs_vec(0) !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL drain_idle dut0: got %h expected %h", obs_vec(0), exp_vec(0));
        end
    endtask

    task automatic test_load_err_down();
        drive(1, 0, 0, 0, 0, 4'd0, 0);
        cycle();
        drive(0, 1, 0, 0, 0, 4'd0, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 4'd9, 0);
        cycle();
        n_checks++;
        if ({le0, b0, v0} !== {1'b1, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL load_err_pulse dut0: got err %b bin %0d valid %b expected 1 0 1", le0, b0, v0);
        end
        drive(0, 0, 0, 0, 0, 4'd0, 1);
        cycle();
        n_checks++;
        if ({le0, b0, g0, w0} !== {1'b0, 4'd15, 4'b1000, 1'b1}) begin
            n_fail++;
            $display("FAIL down_wrap dut0: got err %b bin %0d gray %b wrap %b expected 0 15 1000 1", le0, b0, g0, w0);
        end
        cycle();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL down_after dut%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_rst_mid_run();
        logic [W-1:0] prev_g;
        drive(0, 1, 0, 1, 1, 4'd6, 1);
        cycle();
        cycle();
        drive(0, 0, 0, 1, 0, 4'd0, 0);
        cycle();
        drive(1, 0, 0, 1, 0, 4'd0, 0);
        cycle();
        n_checks++;
        if ({v0, g0, b0, w0, le0, bz0} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_run dut0: got %h expected 0", obs_vec(0));
        end
        drive(0, 1, 0, 1, 0, 4'd0, 1);
        cycle();
        drive(0, 0, 0, 1, 0, 4'd0, 1);
        for (int i = 0; i < 16; i++) begin
            prev_g = g0;
            cycle();
            n_checks++;
            if ($countones(prev_g ^ g0) != 1 || obs_vec(0) !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL sweep_step%0d: got gray %b after %b (%h) expected %h", i, g0, prev_g, obs_vec(0), exp_vec(0));
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] prev_g;
        bit           was_xfer;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  1'($urandom), $urandom_range(0, 5) == 0, W'($urandom), $urandom_range(0, 3) != 0);
            prev_g   = g0;
            was_xfer = v0 && out_ready && !rst;
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d: got %h expected %h", k, i, obs_vec(k), exp_vec(k));
                end
            end
            if (was_xfer && v0) begin
                n_checks++;
                if ($countones(prev_g ^ g0) != 1) begin
                    n_fail++;
                    $display("FAIL random_gray cyc%0d: got %b after %b", i, g0, prev_g);
                end
            end
        end
    endtask

    initial begin
        drive(1, 0, 0, 1, 0, 4'd0, 0);
        test_reset();
        test_load_start();
        test_wrap();
        test_backpressure();
        test_stop_drain();
        test_load_err_down();
        test_rst_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
